// File: rtl/mld_7_4_serial_encoder.sv
// Serial systematic (7,4) cyclic encoder, g(x)=1+x+x^3, MSB first.
// Takes a 4-bit message over valid/ready and emits a 7-bit frame, with optional per-bit error injection.
module mld_7_4_serial_encoder #(
    parameter int INJECT_EN    = 1,
    parameter int BACK_TO_BACK = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       msg_valid,
    output logic       msg_ready,
    input  logic [3:0] msg_data,
    input  logic [6:0] err_mask,
    output logic       encoded_bit_stream,
    output logic       frame_valid,
    output logic       frame_done
);

    typedef enum logic {IDLE, SEND} state_t;

    state_t     state_q, state_d;
    logic [2:0] k_q, k_d;
    logic [3:0] msg_q, msg_d;
    logic [6:0] mask_q, mask_d;
    logic [2:0] lfsr_q, lfsr_d;
    logic       accept;
    logic       fb;
    logic       cw_bit;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            k_q     <= 3'd0;
            msg_q   <= 4'd0;
            mask_q  <= 7'd0;
            lfsr_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            msg_q   <= msg_d;
            mask_q  <= mask_d;
            lfsr_q  <= lfsr_d;
        end
    end

    // Outputs derive from registered state only: no input-to-output paths.
    assign frame_valid        = (state_q == SEND);
    assign frame_done         = frame_valid && (k_q == 3'd6);
    assign msg_ready          = (state_q == IDLE) ||
                                (frame_done && (BACK_TO_BACK != 0));
    assign accept             = msg_valid && msg_ready;
    assign cw_bit             = (k_q < 3'd4) ? msg_q[3] : lfsr_q[2];
    assign encoded_bit_stream = frame_valid && (cw_bit ^ mask_q[6]);
    assign fb                 = msg_q[3] ^ lfsr_q[2];

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        msg_d   = msg_q;
        mask_d  = mask_q;
        lfsr_d  = lfsr_q;

        if (state_q == SEND) begin
            // Message and mask both shift left so bit [MSB] is always the current position.
            mask_d = {mask_q[5:0], 1'b0};
            if (k_q < 3'd4) begin
                msg_d  = {msg_q[2:0], 1'b0};
                lfsr_d = {lfsr_q[1], lfsr_q[0] ^ fb, fb};
            end else begin
                lfsr_d = {lfsr_q[1:0], 1'b0};
            end
            if (k_q == 3'd6) begin
                state_d = IDLE;
                k_d     = 3'd0;
            end else begin
                k_d = k_q + 3'd1;
            end
        end

        if (accept) begin
            state_d = SEND;
            k_d     = 3'd0;
            msg_d   = msg_data;
            mask_d  = (INJECT_EN != 0) ? err_mask : 7'd0;
            lfsr_d  = 3'd0;
        end
    end

endmodule

// File: doc/mld_7_4_serial_encoder.md
Name: mld_7_4_serial_encoder

Overview:
- Upstream stage of the (7,4) majority-logic decoder.
- Accepts 4-bit messages over a valid/ready handshake and emits systematic cyclic (7,4) codewords, generator g(x)=1+x+x^3, as a serial bit stream.
- Codewords go out high-order coefficient first, with a frame-valid qualifier that drives the decoder's load input.
- An optional per-frame error mask flips chosen codeword bits so benches can exercise decoder correction.

Parameters:
- INJECT_EN, default 1: 1 applies err_mask to output bits; 0 ignores err_mask (treated as all zeros).
- BACK_TO_BACK, default 1: 1 lets a new message be accepted during the last bit of the current frame (gapless frames); 0 requires one idle cycle between frames.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- msg_valid  input  1  msg_data and err_mask are valid.
- msg_ready  output  1  encoder can accept a message this cycle.
- msg_data  input  4  message: bit3=m3 (sent first) to bit0=m0.
- err_mask  input  7  error mask, bit6 applies to the first transmitted bit, bit0 to the last.
- encoded_bit_stream  output  1  serial codeword bit (after mask).
- frame_valid  output  1  high while encoded_bit_stream carries a codeword bit; connects to decoder load.
- frame_done  output  1  one-cycle pulse coincident with the 7th (last) bit of a frame.

Behaviour:
- Reset (reset=0 at a clock edge): state IDLE, bit counter 0, LFSR 000, shift/mask registers 0. Outputs: msg_ready=1, encoded_bit_stream=0, frame_valid=0, frame_done=0. Reset takes precedence over everything; a reset mid-frame aborts the frame, and frame_valid is 0 from the next edge. No partial frame resumes.
- States: IDLE and SEND. Counter k runs 0..6 inside SEND.
- Accept: msg_valid & msg_ready at an edge latches msg_data and (err_mask & {7{INJECT_EN}}), clears the LFSR, enters SEND, k=0.
- Latency: the first codeword bit is registered on encoded_bit_stream in the cycle after the accept edge. Bits occupy 7 consecutive cycles.
- Codeword order: c6..c0 = m3,m2,m1,m0,p2,p1,p0, where p(x) = x^3·m(x) mod g(x).
- LFSR (r2,r1,r0) during k=0..3, input bit b=m(3-k):
  - fb=b^r2
  - r2<=r1
  - r1<=r0^fb
  - r0<=fb
- During k=4..6: output r2, then shift r2<=r1, r1<=r0, r0<=0.
- Output bit at position k = codeword bit ^ mask[6-k]. Masking never alters the LFSR.
- msg_ready:
  - 1 in IDLE.
  - In SEND, 1 only during k=6 when BACK_TO_BACK=1; otherwise 0.
  - When BACK_TO_BACK=0, SEND returns to IDLE after k=6, so at least one idle cycle (frame_valid=0) separates frames.
- Accept at k=6 (BACK_TO_BACK=1): the next cycle shows bit k=0 of the new frame, frame_valid stays 1, and frame_done pulses only at k=6.
- End of frame with no new message: IDLE, frame_valid=0, encoded_bit_stream=0.
- msg_valid while msg_ready=0 is ignored. The source must hold data until accepted.
- frame_done=1 exactly when frame_valid=1 and k=6.

Test Plan:
- Reset, then msg_data=0111, err_mask=0 -> over 7 cycles after accept, encoded_bit_stream=0,1,1,1,0,1,0 with frame_valid=1 throughout; frame_done high on the 7th bit only.
- msg_data=1000, then 1011, then 1111, held back-to-back with msg_valid=1, BACK_TO_BACK=1 -> 21 contiguous bits 1000101 1011000 1111111; frame_valid never drops; frame_done pulses on bits 7, 14 and 21.
- msg_data=0111, err_mask=0000100 -> stream 0111110 (bit c2 flipped). The same stimulus with INJECT_EN=0 -> 0111010.
- BACK_TO_BACK=0, two messages offered continuously -> one cycle with frame_valid=0 and encoded_bit_stream=0 between frames; msg_ready=0 throughout SEND.
- reset=0 asserted at the 3rd bit of a frame for msg_data=1111 -> next cycle frame_valid=0 and encoded_bit_stream=0. After release, msg_data=0000 yields 0000000 with correct framing; no residue from the aborted parity.
- msg_valid pulsed while msg_ready=0 mid-frame -> message not taken; the current frame completes unchanged.
